// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: exception codes, ctrl ops,
// control-register map and sequencer state.
package pipe_ctrl_pkg;

  localparam logic [2:0] EXP_NONE     = 3'd0;
  localparam logic [2:0] EXP_INT      = 3'd1;
  localparam logic [2:0] EXP_UNDEF    = 3'd2;
  localparam logic [2:0] EXP_OVFL     = 3'd3;
  localparam logic [2:0] EXP_MISALIGN = 3'd4;
  localparam logic [2:0] EXP_TRAP     = 3'd5;
  localparam logic [2:0] EXP_PRIV     = 3'd6;

  localparam logic [1:0] CTRL_NOP  = 2'd0;
  localparam logic [1:0] CTRL_ERET = 2'd1;
  localparam logic [1:0] CTRL_HALT = 2'd2;

  localparam int CREG_STATUS   = 0;
  localparam int CREG_INT_MASK = 1;
  localparam int CREG_INT_PEND = 2;
  localparam int CREG_EXP_CODE = 3;
  localparam int CREG_EXP_VEC  = 4;
  localparam int CREG_EPC      = 5;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Redirect event chosen for the current cycle (at most one)
  typedef enum logic [2:0] {
    EV_NONE,
    EV_EXC,
    EV_INT,
    EV_ERET,
    EV_HALT,
    EV_WAKE
  } event_t;

  function automatic logic [29:0] pc_inc(input logic [29:0] pc);
    return pc + 30'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the IF/ID/EX/MEM CPU: merges stalls, MEM-stage
// events and interrupts into stall/flush/redirect, and owns the control registers.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int IRQ_W   = 8,
  parameter int CREG_AW = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_busy,
  input  logic               ld_busy,
  input  logic               mem_en,
  input  logic [29:0]        mem_pc,
  input  logic [2:0]         mem_exp_code,
  input  logic [1:0]         mem_ctrl_op,
  input  logic [IRQ_W-1:0]   irq,
  input  logic               creg_we,
  input  logic [CREG_AW-1:0] creg_wr_addr,
  input  logic [31:0]        creg_wr_data,
  input  logic [CREG_AW-1:0] creg_rd_addr,
  output logic [31:0]        creg_rd_data,
  output logic               if_stall,
  output logic               id_stall,
  output logic               ex_stall,
  output logic               mem_stall,
  output logic               if_flush,
  output logic               id_flush,
  output logic               ex_flush,
  output logic               mem_flush,
  output logic [29:0]        new_pc,
  output logic               int_detect
);

  localparam logic [CREG_AW-1:0] A_STATUS   = CREG_AW'(CREG_STATUS);
  localparam logic [CREG_AW-1:0] A_INT_MASK = CREG_AW'(CREG_INT_MASK);
  localparam logic [CREG_AW-1:0] A_INT_PEND = CREG_AW'(CREG_INT_PEND);
  localparam logic [CREG_AW-1:0] A_EXP_CODE = CREG_AW'(CREG_EXP_CODE);
  localparam logic [CREG_AW-1:0] A_EXP_VEC  = CREG_AW'(CREG_EXP_VEC);
  localparam logic [CREG_AW-1:0] A_EPC      = CREG_AW'(CREG_EPC);

  state_t             state_reg, state_next;
  logic               ie_reg, ie_next;
  logic               pie_reg, pie_next;
  logic [IRQ_W-1:0]   mask_reg, mask_next;
  logic [2:0]         code_reg, code_next;
  logic [29:0]        vector_reg, vector_next;
  logic [29:0]        epc_reg, epc_next;
  logic [29:0]        halt_pc_reg, halt_pc_next;

  event_t             ev;
  logic               halted;
  logic               stall;
  logic               accept;
  logic               int_raw;
  logic               wr_en;
  logic [IRQ_W-1:0]   int_pend;
  logic               unused_wr_bits;

  assign unused_wr_bits = ^creg_wr_data[31:30];

  assign halted   = (state_reg == ST_HALT);
  assign int_pend = irq & ~mask_reg;
  assign int_raw  = ie_reg & (|int_pend);
  // A halted core has no load in flight, so only the IF bus can stall it
  assign stall    = if_busy | (ld_busy & ~halted);
  assign accept   = ~stall & mem_en & ~halted;

  always_comb begin
    ev = EV_NONE;
    if (halted) begin
      if (int_raw) ev = EV_WAKE;
    end else if (accept) begin
      if (mem_exp_code != EXP_NONE)       ev = EV_EXC;
      else if (int_raw)                   ev = EV_INT;
      else if (mem_ctrl_op == CTRL_ERET)  ev = EV_ERET;
      else if (mem_ctrl_op == CTRL_HALT)  ev = EV_HALT;
    end
  end

  always_comb begin
    if_stall   = 1'b0;
    id_stall   = 1'b0;
    ex_stall   = 1'b0;
    mem_stall  = 1'b0;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    ex_flush   = 1'b0;
    mem_flush  = 1'b0;
    new_pc     = '0;
    int_detect = 1'b0;
    if (!reset) begin
      int_detect = int_raw;
      // IF stays frozen while halted, released on the wake-up cycle
      if_stall   = stall | (halted & ~int_raw);
      id_stall   = stall;
      ex_stall   = stall;
      mem_stall  = stall;
      case (ev)
        EV_EXC: begin
          {if_flush, id_flush, ex_flush, mem_flush} = 4'b1111;
          new_pc = vector_reg;
        end
        EV_INT, EV_WAKE: begin
          {if_flush, id_flush, ex_flush} = 3'b111;
          new_pc = vector_reg;
        end
        EV_ERET: begin
          {if_flush, id_flush, ex_flush} = 3'b111;
          new_pc = epc_reg;
        end
        EV_HALT: begin
          {if_flush, id_flush, ex_flush} = 3'b111;
          new_pc = pc_inc(mem_pc);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next   = state_reg;
    ie_next      = ie_reg;
    pie_next     = pie_reg;
    mask_next    = mask_reg;
    code_next    = code_reg;
    vector_next  = vector_reg;
    epc_next     = epc_reg;
    halt_pc_next = halt_pc_reg;

    wr_en = creg_we & ~stall & (ev != EV_EXC);
    if (wr_en) begin
      case (creg_wr_addr)
        A_STATUS:   {pie_next, ie_next} = creg_wr_data[1:0];
        A_INT_MASK: mask_next   = creg_wr_data[IRQ_W-1:0];
        A_EXP_CODE: code_next   = creg_wr_data[2:0];
        A_EXP_VEC:  vector_next = creg_wr_data[29:0];
        A_EPC:      epc_next    = creg_wr_data[29:0];
        default: ;
      endcase
    end

    // Event updates come last so they override a write to the same register
    case (ev)
      EV_EXC: begin
        epc_next  = mem_pc;
        code_next = mem_exp_code;
        pie_next  = ie_reg;
        ie_next   = 1'b0;
      end
      EV_INT: begin
        epc_next  = pc_inc(mem_pc);
        code_next = EXP_INT;
        pie_next  = ie_reg;
        ie_next   = 1'b0;
      end
      EV_WAKE: begin
        epc_next   = halt_pc_reg;
        code_next  = EXP_INT;
        pie_next   = ie_reg;
        ie_next    = 1'b0;
        state_next = ST_RUN;
      end
      EV_ERET: begin
        ie_next  = pie_reg;
        pie_next = pie_reg;
      end
      EV_HALT: begin
        halt_pc_next = pc_inc(mem_pc);
        state_next   = ST_HALT;
      end
      default: ;
    endcase
  end

  always_comb begin
    creg_rd_data = '0;
    case (creg_rd_addr)
      A_STATUS:   creg_rd_data[1:0]       = {pie_reg, ie_reg};
      A_INT_MASK: creg_rd_data[IRQ_W-1:0] = mask_reg;
      A_INT_PEND: creg_rd_data[IRQ_W-1:0] = int_pend;
      A_EXP_CODE: creg_rd_data[2:0]       = code_reg;
      A_EXP_VEC:  creg_rd_data[29:0]      = vector_reg;
      A_EPC:      creg_rd_data[29:0]      = epc_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_RUN;
      ie_reg      <= 1'b0;
      pie_reg     <= 1'b0;
      mask_reg    <= '1;
      code_reg    <= '0;
      vector_reg  <= '0;
      epc_reg     <= '0;
      halt_pc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ie_reg      <= ie_next;
      pie_reg     <= pie_next;
      mask_reg    <= mask_next;
      code_reg    <= code_next;
      vector_reg  <= vector_next;
      epc_reg     <= epc_next;
      halt_pc_reg <= halt_pc_next;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic,
// all cycles compared against a behavioural model of the sequencer.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int IRQ_W   = 8;
  localparam int CREG_AW = 5;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic               reset, if_busy, ld_busy, mem_en;
  logic [29:0]        mem_pc;
  logic [2:0]         mem_exp_code;
  logic [1:0]         mem_ctrl_op;
  logic [IRQ_W-1:0]   irq;
  logic               creg_we;
  logic [CREG_AW-1:0] creg_wr_addr, creg_rd_addr;
  logic [31:0]        creg_wr_data, creg_rd_data;
  logic               if_stall, id_stall, ex_stall, mem_stall;
  logic               if_flush, id_flush, ex_flush, mem_flush;
  logic [29:0]        new_pc;
  logic               int_detect;

  pipe_ctrl #(.IRQ_W(IRQ_W), .CREG_AW(CREG_AW)) dut (
    .clk(clk), .reset(reset), .if_busy(if_busy), .ld_busy(ld_busy),
    .mem_en(mem_en), .mem_pc(mem_pc), .mem_exp_code(mem_exp_code),
    .mem_ctrl_op(mem_ctrl_op), .irq(irq), .creg_we(creg_we),
    .creg_wr_addr(creg_wr_addr), .creg_wr_data(creg_wr_data),
    .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush),
    .ex_flush(ex_flush), .mem_flush(mem_flush), .new_pc(new_pc),
    .int_detect(int_detect)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Architectural model
  bit          m_ie, m_pie, m_halted;
  logic [7:0]  m_mask;
  logic [2:0]  m_code;
  logic [29:0] m_vec, m_epc, m_halt_pc;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd0:    return {30'b0, m_pie, m_ie};
      5'd1:    return {24'b0, m_mask};
      5'd2:    return {24'b0, irq & ~m_mask};
      5'd3:    return {29'b0, m_code};
      5'd4:    return {2'b0, m_vec};
      5'd5:    return {2'b0, m_epc};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [7:0]  pend;
    bit          idet, busy, front, memfl, take_exc;
    logic [29:0] npc, pc1;
    string       kind;
    pend     = irq & ~m_mask;
    idet     = m_ie && (pend != 8'h0);
    busy     = if_busy || (ld_busy && !m_halted);
    front    = 0;
    memfl    = 0;
    take_exc = 0;
    npc      = 30'h0;
    pc1      = mem_pc + 30'd1;
    kind     = "none";

    check("rd_data", creg_rd_data, m_read(creg_rd_addr));

    if (reset) begin
      check("rst_outs", {if_stall, id_stall, ex_stall, mem_stall,
                         if_flush, id_flush, ex_flush, mem_flush, int_detect}, 32'h0);
      check("rst_npc", new_pc, 32'h0);
      m_ie = 0; m_pie = 0; m_halted = 0; m_mask = 8'hFF; m_code = 0;
      m_vec = 0; m_epc = 0; m_halt_pc = 0;
      $display("cyc=%0d reset", cyc);
      return;
    end

    if (m_halted) begin
      if (idet) begin kind = "wake"; front = 1; npc = m_vec; end
    end else if (!busy && mem_en) begin
      if (mem_exp_code != 3'd0) begin
        kind = "exc"; take_exc = 1; front = 1; memfl = 1; npc = m_vec;
      end else if (idet) begin
        kind = "int"; front = 1; npc = m_vec;
      end else if (mem_ctrl_op == 2'd1) begin
        kind = "eret"; front = 1; npc = m_epc;
      end else if (mem_ctrl_op == 2'd2) begin
        kind = "halt"; front = 1; npc = pc1;
      end
    end

    check("int_detect", int_detect, idet);
    check("if_stall", if_stall, busy || (m_halted && !idet));
    check("idexmem_stall", {id_stall, ex_stall, mem_stall}, busy ? 3'b111 : 3'b000);
    check("front_flush", {if_flush, id_flush, ex_flush}, front ? 3'b111 : 3'b000);
    check("mem_flush", mem_flush, memfl);
    check("new_pc", new_pc, npc);
    $display("cyc=%0d ev=%s halted=%0d busy=%0d npc=0x%0h", cyc, kind, m_halted, busy, npc);

    if (creg_we && !busy && !take_exc) begin
      case (creg_wr_addr)
        5'd0: begin m_pie = creg_wr_data[1]; m_ie = creg_wr_data[0]; end
        5'd1: m_mask = creg_wr_data[7:0];
        5'd3: m_code = creg_wr_data[2:0];
        5'd4: m_vec  = creg_wr_data[29:0];
        5'd5: m_epc  = creg_wr_data[29:0];
        default: ;
      endcase
    end
    if (kind == "exc") begin
      m_epc = mem_pc; m_code = mem_exp_code; m_pie = m_ie; m_ie = 0;
    end else if (kind == "int") begin
      m_epc = pc1; m_code = 3'd1; m_pie = m_ie; m_ie = 0;
    end else if (kind == "wake") begin
      m_epc = m_halt_pc; m_code = 3'd1; m_pie = m_ie; m_ie = 0; m_halted = 0;
    end else if (kind == "eret") begin
      m_ie = m_pie;
    end else if (kind == "halt") begin
      m_halt_pc = pc1; m_halted = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    reset = 0; if_busy = 0; ld_busy = 0; mem_en = 0; mem_pc = 30'h0;
    mem_exp_code = EXP_NONE; mem_ctrl_op = CTRL_NOP; irq = '0;
    creg_we = 0; creg_wr_addr = '0; creg_wr_data = '0; creg_rd_addr = '0;
  endtask

  task automatic creg_write(input logic [4:0] a, input logic [31:0] d);
    idle();
    creg_we = 1; creg_wr_addr = a; creg_wr_data = d;
    tick();
    creg_we = 0;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    creg_rd_addr = a;
    #1;
    check(tag, creg_rd_data, exp);
  endtask

  logic [2:0] exc_tab [5];

  initial begin
    exc_tab = '{EXP_UNDEF, EXP_OVFL, EXP_MISALIGN, EXP_TRAP, EXP_PRIV};
    idle();
    reset = 1;
    tick();
    reset = 0;

    // Reset values
    rd_check("rst_status", 5'd0, 32'h0);
    rd_check("rst_mask",   5'd1, 32'hFF);
    rd_check("rst_pend",   5'd2, 32'h0);
    rd_check("rst_code",   5'd3, 32'h0);
    rd_check("rst_vec",    5'd4, 32'h0);
    rd_check("rst_epc",    5'd5, 32'h0);
    check("rst_flush", {if_flush, id_flush, ex_flush, mem_flush}, 32'h0);

    creg_write(5'd4, 32'h1000);

    // Exception held off by a busy IF bus
    idle(); if_busy = 1; mem_en = 1; mem_exp_code = EXP_OVFL; mem_pc = 30'h100;
    tick(); tick();
    if_busy = 0; #1;
    check("t2_flush", {if_flush, id_flush, ex_flush, mem_flush}, 32'hF);
    check("t2_npc", new_pc, 32'h1000);
    tick();
    idle();
    rd_check("t2_epc", 5'd5, 32'h100);
    rd_check("t2_code", 5'd3, 32'h3);
    rd_check("t2_status", 5'd0, 32'h0);

    // Interrupt with EPC wrap
    creg_write(5'd1, 32'hFE);
    creg_write(5'd0, 32'h1);
    idle(); irq = 8'h01; mem_en = 1; mem_pc = 30'h3FFFFFFF; #1;
    check("t3_idet", int_detect, 32'h1);
    check("t3_memfl", mem_flush, 32'h0);
    check("t3_front", {if_flush, id_flush, ex_flush}, 32'h7);
    tick();
    idle();
    rd_check("t3_epc", 5'd5, 32'h0);
    rd_check("t3_code", 5'd3, 32'h1);
    rd_check("t3_status", 5'd0, 32'h2);

    // Exception beats interrupt and suppresses the EPC write
    creg_write(5'd0, 32'h1);
    idle(); irq = 8'h01; mem_en = 1; mem_pc = 30'h2A0; mem_exp_code = EXP_TRAP;
    creg_we = 1; creg_wr_addr = 5'd5; creg_wr_data = 32'h999; #1;
    check("t4_memfl", mem_flush, 32'h1);
    tick();
    idle();
    rd_check("t4_epc", 5'd5, 32'h2A0);
    rd_check("t4_code", 5'd3, 32'h5);
    rd_check("t4_status", 5'd0, 32'h2);

    // ERET
    creg_write(5'd5, 32'h40);
    creg_write(5'd0, 32'h2);
    idle(); mem_en = 1; mem_ctrl_op = CTRL_ERET; #1;
    check("t5_npc", new_pc, 32'h40);
    check("t5_front", {if_flush, id_flush, ex_flush, mem_flush}, 32'hE);
    tick();
    idle();
    rd_check("t5_status", 5'd0, 32'h3);

    // HALT then interrupt wake-up
    idle(); mem_en = 1; mem_ctrl_op = CTRL_HALT; mem_pc = 30'h20; #1;
    check("t6_npc", new_pc, 32'h21);
    tick();
    idle(); ld_busy = 1; #1;
    check("t6_ifstall", if_stall, 32'h1);
    check("t6_memstall", mem_stall, 32'h0);
    tick(); tick();
    idle(); irq = 8'h01; #1;
    check("t6_idet", int_detect, 32'h1);
    check("t6_npc_wake", new_pc, 32'h1000);
    check("t6_ifstall_wake", if_stall, 32'h0);
    tick();
    idle();
    rd_check("t6_epc", 5'd5, 32'h21);
    rd_check("t6_code", 5'd3, 32'h1);
    rd_check("t6_status", 5'd0, 32'h2);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int op_sel;
      reset        = ($urandom_range(0, 99) == 0);
      if_busy      = ($urandom_range(0, 4) == 0);
      ld_busy      = ($urandom_range(0, 4) == 0);
      mem_en       = ($urandom_range(0, 3) != 0);
      mem_pc       = 30'($urandom);
      mem_exp_code = ($urandom_range(0, 5) == 0) ? exc_tab[$urandom_range(0, 4)] : EXP_NONE;
      op_sel       = $urandom_range(0, 15);
      mem_ctrl_op  = (op_sel < 2) ? CTRL_ERET : (op_sel == 2) ? CTRL_HALT :
                     (op_sel == 3) ? 2'd3 : CTRL_NOP;
      irq          = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h0;
      creg_we      = ($urandom_range(0, 2) == 0);
      creg_wr_addr = 5'($urandom_range(0, 7));
      creg_wr_data = $urandom;
      creg_rd_addr = 5'($urandom_range(0, 7));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
